// File: rtl/ycbcr_pipe_ctrl.sv
// ycbcr_pipe_ctrl
//   Control side of the YCbCr delay pipe. Delays the camera sync/enable signals
//   by the data latency of the pipe (DELAY_CNT+1 cycles) and gates them so that
//   only whole frames reach downstream logic. Also counts output pixels/lines
//   and flags frames whose geometry differs from H_ACTIVE x V_ACTIVE.
// Ports
//   clk, rst            pixel clock, async active-high reset
//   enable              level run request
//   err_clr             pulse, clears frame_err
//   in_vsync/hsync/de   sync signals aligned with pixels entering the pipe
//   out_vsync/hsync/de  delayed and gated sync signals
//   frame_start         1-cycle pulse on gated out_vsync rising edge
//   pix_cnt             index of the current active pixel in the output line
//   line_cnt            completed active lines in the current output frame
//   busy                FSM not in IDLE
//   frame_err           sticky geometry error flag
//
// state | meaning
// IDLE  | gate closed, waiting for enable
// ARM   | waiting for an in_vsync rising edge to start a whole frame
// RUN   | passing everything; stops at the next frame boundary once enable drops
// DRAIN | gate closed at input, letting in-flight pixels leave the pipe
module ycbcr_pipe_ctrl #(
  parameter int DELAY_CNT = 7,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             err_clr,
  input  logic             in_vsync,
  input  logic             in_hsync,
  input  logic             in_de,
  output logic             out_vsync,
  output logic             out_hsync,
  output logic             out_de,
  output logic             frame_start,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             busy,
  output logic             frame_err
);

  localparam int DEPTH = DELAY_CNT + 1;
  localparam int DRN_W = (DELAY_CNT < 1) ? 1 : $clog2(DELAY_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               stop_pend_q, stop_pend_d;
  // Each stage carries {pass, vsync, hsync, de} so the gate travels with the pixel.
  logic [DEPTH-1:0][3:0] pipe_q, pipe_d;
  logic               ovs_prev_q, ovs_prev_d;
  logic               ode_prev_q, ode_prev_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
  logic               line_bad_q, line_bad_d;
  logic               first_frame_q, first_frame_d;
  logic               frame_err_q, frame_err_d;

  logic pass;
  logic vs_rise;
  logic de_rise;
  logic de_fall;
  logic err_set;

  // Input-side FSM. Stage 0 of the pipe holds last cycle's in_vsync.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stop_pend_d = stop_pend_q;
    pass        = 1'b0;
    vs_rise     = in_vsync & ~pipe_q[0][2];
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          pass    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // A dropped enable is remembered until the frame boundary, even if it returns.
        if (!enable) stop_pend_d = 1'b1;
        if (vs_rise && (stop_pend_q || !enable)) begin
          state_d     = DRAIN;
          drain_cnt_d = DRN_W'(DELAY_CNT);
          stop_pend_d = 1'b0;
        end else begin
          pass = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) state_d = IDLE;
        else drain_cnt_d = drain_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pipe_d[0] = {pass, in_vsync, in_hsync, in_de};
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign out_vsync = pipe_q[DEPTH-1][2] & pipe_q[DEPTH-1][3];
  assign out_hsync = pipe_q[DEPTH-1][1] & pipe_q[DEPTH-1][3];
  assign out_de    = pipe_q[DEPTH-1][0] & pipe_q[DEPTH-1][3];

  // Output-side counters and geometry check.
  always_comb begin
    frame_start = out_vsync & ~ovs_prev_q;
    de_rise     = out_de & ~ode_prev_q;
    de_fall     = ~out_de & ode_prev_q;
    ovs_prev_d  = out_vsync;
    ode_prev_d  = out_de;

    // pix_cnt_q holds pixels already seen in this line; a rising de starts a new line at 0.
    pix_cnt   = de_rise ? '0 : pix_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (out_de) begin
      if (de_rise) pix_cnt_d = CNT_W'(1);
      else if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
    end

    line_cnt_d = line_cnt_q;
    line_bad_d = line_bad_q;
    if (frame_start) begin
      line_cnt_d = '0;
      line_bad_d = 1'b0;
    end else if (de_fall) begin
      if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 1'b1;
      if (pix_cnt_q != CNT_W'(H_ACTIVE)) line_bad_d = 1'b1;
    end

    // The first passed vsync after a closed gate has no preceding frame to judge.
    first_frame_d = first_frame_q;
    if (!pipe_q[DEPTH-1][3]) first_frame_d = 1'b1;
    else if (frame_start) first_frame_d = 1'b0;

    err_set = frame_start & ~first_frame_q &
              ((line_cnt_q != CNT_W'(V_ACTIVE)) | line_bad_q);
    frame_err_d = frame_err_q;
    if (err_set) frame_err_d = 1'b1;
    else if (err_clr) frame_err_d = 1'b0;
  end

  assign line_cnt  = line_cnt_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      drain_cnt_q   <= '0;
      stop_pend_q   <= 1'b0;
      pipe_q        <= '0;
      ovs_prev_q    <= 1'b0;
      ode_prev_q    <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_bad_q    <= 1'b0;
      first_frame_q <= 1'b1;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      stop_pend_q   <= stop_pend_d;
      pipe_q        <= pipe_d;
      ovs_prev_q    <= ovs_prev_d;
      ode_prev_q    <= ode_prev_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_bad_q    <= line_bad_d;
      first_frame_q <= first_frame_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_ycbcr_pipe_ctrl.sv
// Directed bench for ycbcr_pipe_ctrl with a 4x3 frame geometry and 8-cycle latency.
module tb_ycbcr_pipe_ctrl;
  localparam int CNT_W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic err_clr = 1'b0;
  logic in_vsync = 1'b0;
  logic in_hsync = 1'b0;
  logic in_de = 1'b0;
  logic out_vsync, out_hsync, out_de, frame_start, busy, frame_err;
  logic [CNT_W-1:0] pix_cnt, line_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt = 0;
  int de_cnt = 0;
  int pix_log[$];
  int fs_before, de_before;

  ycbcr_pipe_ctrl #(
    .DELAY_CNT(7), .H_ACTIVE(4), .V_ACTIVE(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .in_vsync(in_vsync), .in_hsync(in_hsync), .in_de(in_de),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
    .frame_start(frame_start), .pix_cnt(pix_cnt), .line_cnt(line_cnt),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (out_de) begin
      de_cnt++;
      pix_log.push_back(int'(pix_cnt));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse;
    in_vsync = 1'b1;
    tick;
    tick;
    in_vsync = 1'b0;
    tick;
  endtask

  task automatic send_lines(input int n, input int long_idx);
    for (int l = 0; l < n; l++) begin
      in_hsync = 1'b1;
      tick;
      in_hsync = 1'b0;
      tick;
      in_de = 1'b1;
      repeat ((l == long_idx) ? 5 : 4) tick;
      in_de = 1'b0;
      tick;
      tick;
    end
  endtask

  task automatic flush;
    repeat (12) tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      in_vsync = i[0];
      in_hsync = i[1];
      in_de    = ~i[0];
      enable   = 1'b1;
      tick;
    end
    chk("rst_out_vsync", out_vsync, 0);
    chk("rst_out_hsync", out_hsync, 0);
    chk("rst_out_de", out_de, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_frame_err", frame_err, 0);
    in_vsync = 0; in_hsync = 0; in_de = 0; enable = 0;
    #2 rst = 1'b0;
    tick;
    tick;
    chk("idle_busy", busy, 0);

    // T2: latency of first vsync after ARM
    enable = 1'b1;
    tick;
    chk("arm_busy", busy, 1);
    in_vsync = 1'b1;
    tick;
    tick;
    in_vsync = 1'b0;
    repeat (5) tick;
    chk("lat_vs_before", out_vsync, 0);
    chk("lat_fs_before", frame_start, 0);
    tick;
    chk("lat_vs_at8", out_vsync, 1);
    chk("lat_fs_at8", frame_start, 1);
    tick;
    chk("lat_fs_pulse", frame_start, 0);
    chk("lat_vs_hold", out_vsync, 1);
    send_lines(3, -1);
    flush;
    chk("f1_line_cnt", line_cnt, 3);
    chk("f1_frame_err", frame_err, 0);
    chk("f1_fs_cnt", fs_cnt, 1);
    chk("f1_pix_log_len", pix_log.size(), 12);
    for (int i = 0; i < 12 && i < pix_log.size(); i++)
      chk("f1_pix_idx", pix_log[i], i % 4);

    // T4: good frame closes cleanly, frame with a 5-pixel line flags at next vsync
    vs_pulse;
    send_lines(3, 1);
    flush;
    chk("f2_good_prev_err", frame_err, 0);
    chk("f2_line_cnt", line_cnt, 3);
    vs_pulse;
    repeat (8) tick;
    chk("f3_err_set", frame_err, 1);
    chk("f3_line_cnt_clr", line_cnt, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("f3_err_clr", frame_err, 0);

    // T5: drop enable mid-frame, frame completes, next vsync is blocked
    send_lines(1, -1);
    enable = 1'b0;
    send_lines(2, -1);
    flush;
    chk("stop_line_cnt", line_cnt, 3);
    chk("stop_busy_run", busy, 1);
    fs_before = fs_cnt;
    in_vsync = 1'b1;
    tick;
    tick;
    in_vsync = 1'b0;
    repeat (6) tick;
    chk("stop_busy_drain", busy, 1);
    tick;
    chk("stop_busy_fall", busy, 0);
    repeat (12) tick;
    chk("stop_vs_blocked", fs_cnt, fs_before);
    chk("stop_no_err", frame_err, 0);

    // T3: arm while a line is active; that partial line must not leak
    in_de = 1'b1;
    tick;
    tick;
    enable = 1'b1;
    tick;
    tick;
    in_de = 1'b0;
    tick;
    de_before = de_cnt;
    repeat (12) tick;
    chk("arm_mid_no_de", de_cnt, de_before);
    chk("arm_mid_busy", busy, 1);
    vs_pulse;
    send_lines(3, -1);
    flush;
    chk("arm_mid_fs", fs_cnt, fs_before + 1);
    chk("arm_mid_de", de_cnt, de_before + 12);
    chk("arm_mid_line_cnt", line_cnt, 3);
    chk("arm_mid_err", frame_err, 0);

    // T6: async reset in the middle of a passed line
    vs_pulse;
    send_lines(2, -1);
    for (int i = 0; i < 20 && !out_de; i++) tick;
    chk("t6_de_seen", out_de, 1);
    tick;
    chk("t6_pix_cnt", pix_cnt, 1);
    chk("t6_line_cnt", line_cnt, 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_out_de", out_de, 0);
    chk("t6_out_hsync", out_hsync, 0);
    chk("t6_busy", busy, 0);
    chk("t6_line_cnt_rst", line_cnt, 0);
    chk("t6_pix_cnt_rst", pix_cnt, 0);
    #2 rst = 1'b0;
    de_before = de_cnt;
    send_lines(1, -1);
    flush;
    chk("t6_no_pass_wo_vs", de_cnt, de_before);
    chk("t6_rearm_busy", busy, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
